// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and received-byte outputs of the UART receiver.
// Carries perr only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
    logic       rx;
    logic [7:0] charout;
    logic       done;
    logic       ferr;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    modport master (
        input  rx,
`ifdef UART_RX_PARITY_EN
        output perr,
`endif
        output charout,
        output done,
        output ferr,
        output busy
    );

    modport slave (
        output rx,
`ifdef UART_RX_PARITY_EN
        input  perr,
`endif
        input  charout,
        input  done,
        input  ferr,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, mid-bit sampling, CLKDIV clocks per bit.
// Optional even parity bit and perr pulse when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLKDIV = 868
) (
    input logic      clk,
    input logic      n_rst,
    uart_rx_if.master bus
);

    localparam int CW = $clog2(CLKDIV);
    localparam logic [CW-1:0] HALF = CW'(CLKDIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKDIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAITHI
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, WAITHI
    } state_t;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitidx;
    logic [7:0]    shreg;
    logic          sync1;
    logic          srx;
    logic [7:0]    charout;
    logic          done;
    logic          ferr;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          par_bad;
    logic          perr;
`endif

    assign bus.charout = charout;
    assign bus.done    = done;
    assign bus.ferr    = ferr;
    assign bus.busy    = busy;
`ifdef UART_RX_PARITY_EN
    assign bus.perr    = perr;
`endif

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1 <= 1'b1;
            srx   <= 1'b1;
        end else begin
            sync1 <= bus.rx;
            srx   <= sync1;
        end
    end

    // Frame FSM with registered pulses; busy tracks the next state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bitidx  <= '0;
            shreg   <= '0;
            charout <= '0;
            done    <= 1'b0;
            ferr    <= 1'b0;
            busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            perr    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!srx) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt    <= '0;
                        bitidx <= '0;
                        if (!srx) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL) begin
                        cnt           <= '0;
                        shreg[bitidx] <= srx;
                        bitidx        <= bitidx + 3'd1;
                        if (bitidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                // Even parity: the parity bit equals the XOR of the data bits.
                PARITY: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        par_bad <= srx ^ (^shreg);
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        if (srx) begin
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                perr <= 1'b1;
                            end else begin
                                charout <= shreg;
                                done    <= 1'b1;
                            end
`else
                            charout <= shreg;
                            done    <= 1'b1;
`endif
                        end else begin
                            ferr  <= 1'b1;
                            state <= WAITHI;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAITHI: begin
                    cnt <= '0;
                    if (srx) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at CLKDIV=16.
// Define UART_RX_PARITY_EN for both files to cover the parity build.
module tb_uart_rx;

    localparam int DIV = 16;

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    uart_rx_if bus ();

    uart_rx #(.CLKDIV(DIV)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int busy_rises = 0;
    int t_busy = 0;
    int last_lat = -1;
    logic prev_busy = 1'b0;
    logic [7:0] prev_co = 8'h00;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: scoreboard pops, pulse counters, latency capture.
    always @(negedge clk) begin
        if (bus.busy && !prev_busy) begin
            t_busy = cyc;
            busy_rises++;
        end
        prev_busy = bus.busy;
        if (bus.done) begin
            done_cnt++;
            last_lat = cyc - t_busy;
            chk("done_ferr_excl", 32'(bus.ferr), 0);
            chk("sb_underflow", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0)
                chk("charout", 32'(bus.charout), 32'(exp_q.pop_front()));
        end else if (n_rst && bus.charout !== prev_co) begin
            chk("charout_hold", 32'(bus.charout), 32'(prev_co));
        end
        prev_co = bus.charout;
        if (bus.ferr) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
        if (bus.perr) perr_cnt++;
`endif
    end

    task automatic bit_out(input logic v);
        bus.rx = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic par,
                        input logic stopb);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_out(par);
`else
        if (par) begin end
`endif
        bit_out(stopb);
    endtask

    task automatic send_ok(input logic [7:0] b);
        exp_q.push_back(b);
        send(b, ^b, 1'b1);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] msg[7];
        int d0;
        int f0;
        int b0;
        msg = '{8'h56, 8'h30, 8'h31, 8'h2C, 8'h30, 8'h32, 8'h0A};
        bus.rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_charout", 32'(bus.charout), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ferr", 32'(bus.ferr), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        n_rst = 1'b1;
        idle(10);

        send_ok(8'h48);
        idle(20);
        chk("lat_48", 32'(last_lat), 32'(DIV / 2 + 9 * DIV));
        chk("done_48", 32'(done_cnt), 1);
        chk("ferr_48", 32'(ferr_cnt), 0);

        d0 = done_cnt;
        for (int i = 0; i < 7; i++) send_ok(msg[i]);
        idle(20);
        chk("b2b_done", 32'(done_cnt - d0), 7);
        chk("b2b_sb_empty", 32'(exp_q.size()), 0);

        d0 = done_cnt;
        f0 = ferr_cnt;
        b0 = busy_rises;
        bus.rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(10);
        chk("glitch_busy", 32'(bus.busy), 0);
        chk("glitch_seen", 32'(busy_rises - b0), 1);
        idle(20);
        chk("glitch_done", 32'(done_cnt - d0), 0);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 0);

        d0 = done_cnt;
        f0 = ferr_cnt;
        send(8'h55, ^8'h55, 1'b0);
        bus.rx = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        idle(20);
        chk("brk_ferr", 32'(ferr_cnt - f0), 1);
        chk("brk_done", 32'(done_cnt - d0), 0);
        chk("brk_charout", 32'(bus.charout), 32'h0A);
        chk("brk_busy", 32'(bus.busy), 0);
        send_ok(8'hA3);
        idle(20);
        chk("a3_done", 32'(done_cnt - d0), 1);

        d0 = done_cnt;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'(8'h7E >> i));
        bus.rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_charout", 32'(bus.charout), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        n_rst = 1'b1;
        prev_co = 8'h00;
        idle(30);
        send_ok(8'h31);
        idle(20);
        chk("mrst_done", 32'(done_cnt - d0), 1);
        chk("mrst_charout31", 32'(bus.charout), 32'h31);

`ifdef UART_RX_PARITY_EN
        d0 = done_cnt;
        send(8'h07, 1'b0, 1'b1);
        idle(20);
        chk("par_perr", 32'(perr_cnt), 1);
        chk("par_nodone", 32'(done_cnt - d0), 0);
        chk("par_charout", 32'(bus.charout), 32'h31);
        send_ok(8'h07);
        idle(20);
        chk("par_done", 32'(done_cnt - d0), 1);
        chk("par_perr2", 32'(perr_cnt), 1);
`endif

        chk("sb_final_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKDIV, default 868, meaning clock cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port rx, input, 1, asynchronous serial line (idle high, 8N1, LSB first).
REQ-005 SHALL have port charout, output, 8, last correctly received byte; it feeds the control parser's charin.
REQ-006 SHALL have port done, output, 1, one-cycle pulse marking a new valid charout; it feeds the control parser's uartdone.
REQ-007 SHALL have port ferr, output, 1, one-cycle pulse on framing error (stop bit sampled 0).
REQ-008 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all further logic uses the synchronized value srx.
REQ-010 SHALL implement states IDLE, START, DATA, STOP and WAITHI, plus PARITY when UART_RX_PARITY_EN is defined.
REQ-011 SHALL use a bit-period counter cnt of width $clog2(CLKDIV) and a 3-bit bit index; cnt SHALL clear on every state entry and after every sample.
REQ-012 IDLE: srx==0 -> START.
REQ-013 START: at cnt==CLKDIV/2-1 (integer division), sample srx; 0 -> DATA, 1 -> IDLE (glitch rejection; no done, no ferr).
REQ-014 DATA: at each cnt==CLKDIV-1, shift srx into shift register position bitidx, LSB first; after bit 7 -> STOP (or PARITY when enabled).
REQ-015 STOP: at cnt==CLKDIV-1, sample srx.
  - 1: charout <= shift register; done=1 for exactly that one cycle; -> IDLE.
  - 0: ferr=1 for one cycle; charout unchanged; -> WAITHI.
REQ-016 WAITHI: remain until srx==1, then -> IDLE, so a break condition produces exactly one ferr and no done.
REQ-017 done latency SHALL be CLKDIV/2 + 9*CLKDIV cycles (plus CLKDIV with parity) after the cycle in which IDLE sees srx==0.
REQ-018 charout SHALL hold its value between done pulses and SHALL never change without a done pulse.
REQ-019 done and ferr SHALL never be high in the same cycle.
REQ-020 Back-to-back frames (start bit immediately after stop bit) SHALL be received with no byte lost, since IDLE is re-entered at mid-stop.
REQ-021 rx changes mid-bit other than at the sample point SHALL have no effect; there is no majority voting.

Reset
REQ-022 n_rst low SHALL asynchronously force: state=IDLE, cnt=0, bit index=0, shift register=0, charout=8'h00, done=0, ferr=0, busy=0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL discard the partial byte with no done; after release, reception restarts at the next falling edge of srx.

Configuration
REQ-024 Macro UART_RX_PARITY_EN: when defined, the PARITY state follows DATA, samples one even-parity bit at cnt==CLKDIV-1, and adds output perr (1 bit, one-cycle pulse).
  - Parity mismatch with a good stop bit: perr=1 and no done, charout unchanged, then -> IDLE.
  - Parity mismatch with a bad stop bit: ferr=1 only.
REQ-025 When UART_RX_PARITY_EN is undefined, SHALL have no PARITY state and no perr port; the frame is 8N1.

Verification (CLKDIV=16)
REQ-026 Send 8N1 byte 0x48 ('H') -> done one cycle at 152 cycles after start detect, charout=8'h48, ferr never high.
REQ-027 Send 'V','0','1',',','0','2','\n' back-to-back -> seven done pulses, charout sequence 56,30,31,2C,30,32,0A.
REQ-028 Pull rx low for 5 cycles then high -> START rejects it; no done, no ferr, busy returns to 0 by cycle 10.
REQ-029 Send 0x55 with stop bit 0, line held low 100 cycles -> single ferr pulse, charout keeps previous value, no done; a following 0xA3 frame is received correctly.
REQ-030 Assert n_rst during bit 4 of 0x7E, release, then send 0x31 -> charout=8'h00 during reset, exactly one done, charout=8'h31.
REQ-031 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 (wrong) -> perr pulse, no done; the same byte with parity 1 -> done, charout=8'h07.
